carfield_addr_map_ctrl: RTL



---
 rtl/carfield_addr_map_pkg.sv | 71 +++++++
 rtl/carfield_addr_map_decode.sv | 31 +++
 rtl/carfield_addr_map_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/carfield_addr_map_pkg.sv
// Shared types, register offsets and helpers for the Carfield address-map controller.
package carfield_addr_map_pkg;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] size;
  } region_t;

  localparam logic [11:0] OffEnable = 12'h400;
  localparam logic [11:0] OffCtrl   = 12'h404;
  localparam logic [11:0] OffStatus = 12'h408;

  localparam logic [1:0] WBaseLo = 2'd0;
  localparam logic [1:0] WBaseHi = 2'd1;
  localparam logic [1:0] WSizeLo = 2'd2;
  localparam logic [1:0] WSizeHi = 2'd3;

  typedef enum logic [1:0] {
    Idle,
    Pending,
    Apply
  } state_e;

  function automatic logic [31:0] get_word(
    region_t    r,
    logic [1:0] w
  );
    logic [31:0] d;
    unique case (w)
      WBaseLo: d = r.base[31:0];
      WBaseHi: d = r.base[63:32];
      WSizeLo: d = r.size[31:0];
      default: d = r.size[63:32];
    endcase
    return d;
  endfunction

  function automatic region_t put_word(
    region_t     r,
    logic [1:0]  w,
    logic [31:0] d,
    logic [63:0] mask
  );
    region_t n;
    n = r;
    unique case (w)
      WBaseLo: n.base[31:0]  = d;
      WBaseHi: n.base[63:32] = d;
      WSizeLo: n.size[31:0]  = d;
      default: n.size[63:32] = d;
    endcase
    n.base = n.base & mask;
    n.size = n.size & mask;
    return n;
  endfunction

  // One extra bit keeps base+size from wrapping at the top of the space.
  function automatic logic [64:0] region_end(region_t r);
    return {1'b0, r.base} + {1'b0, r.size};
  endfunction

  function automatic logic region_hit(
    region_t     r,
    logic        en,
    logic [64:0] a
  );
    return en && (r.size != '0) &&
           ({1'b0, r.base} <= a) && (a < region_end(r));
  endfunction

endpackage

// File: rtl/carfield_addr_map_decode.sv
// Combinational priority decode of an address against the active region map.
module carfield_addr_map_decode
  import carfield_addr_map_pkg::*;
#(
  parameter int unsigned NumRegions = 8,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned IdxW       = 3
) (
  input  region_t [NumRegions-1:0] map_i,
  input  logic    [NumRegions-1:0] en_i,
  input  logic    [AddrWidth-1:0]  addr_i,
  output logic                     hit_o,
  output logic    [IdxW-1:0]       idx_o
);

  logic [64:0] addr;
  assign addr = 65'(addr_i);

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
      if (region_hit(map_i[i], en_i[i], addr)) begin
        hit_o = 1'b1;
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/carfield_addr_map_ctrl.sv
// Runtime-programmable address map with shadow registers and idle-gated commit.
// Define CARFIELD_ADDR_MAP_OVERLAP_CHECK_EN to reject commits of overlapping maps.
module carfield_addr_map_ctrl
  import carfield_addr_map_pkg::*;
#(
  parameter int unsigned NumRegions = 8,
  parameter int unsigned AddrWidth  = 48,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultBase = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultSize = '0,
  parameter logic [NumRegions-1:0] DefaultEnable = '0,
  localparam int unsigned IdxW =
    (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  logic [11:0]          reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_ready_o,
  output logic                 reg_error_o,
  input  logic                 bus_idle_i,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [AddrWidth-1:0] dec_addr_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic                 dec_hit_o,
  output logic [IdxW-1:0]      dec_idx_o,
  output logic                 commit_pending_o
);

  localparam logic [63:0] AddrMask = (AddrWidth >= 64) ?
    64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << AddrWidth) - 64'd1);

  region_t [NumRegions-1:0] def_map;
  region_t [NumRegions-1:0] shadow_q;
  region_t [NumRegions-1:0] active_q;
  logic    [NumRegions-1:0] shen_q;
  logic    [NumRegions-1:0] acten_q;

  state_e state_q;
  logic   pend_q;
  logic   lock_q;
  logic   ovl_q;
  logic   overlap;

  always_comb begin
    def_map = '0;
    for (int i = 0; i < int'(NumRegions); i++) begin
      def_map[i].base = 64'(DefaultBase[i]);
      def_map[i].size = 64'(DefaultSize[i]);
    end
  end

  logic       aligned;
  logic       is_reg, is_en, is_ctrl, is_stat;
  logic       bad_addr, wr_ok, commit_req;
  logic [4:0] ridx;
  logic [1:0] rword;
  logic [31:0] rdata;

  assign aligned = (reg_addr_i[1:0] == 2'b00);
  assign is_reg  = aligned && (reg_addr_i < 12'(NumRegions * 16));
  assign is_en   = (reg_addr_i == OffEnable);
  assign is_ctrl = (reg_addr_i == OffCtrl);
  assign is_stat = (reg_addr_i == OffStatus);
  assign ridx    = reg_addr_i[8:4];
  assign rword   = reg_addr_i[3:2];

  assign bad_addr = !(is_reg || is_en || is_ctrl || is_stat) ||
                    (is_stat && reg_we_i);

  assign reg_ready_o = reg_req_i;
  assign reg_error_o = reg_req_i &&
                       (bad_addr || (reg_we_i && lock_q));
  assign wr_ok       = reg_req_i && reg_we_i && !reg_error_o;
  assign commit_req  = wr_ok && is_ctrl && reg_wdata_i[0];

  always_comb begin
    rdata = 32'h0;
    unique case (1'b1)
      is_reg: begin
        for (int i = 0; i < int'(NumRegions); i++)
          if (ridx == 5'(i)) rdata = get_word(shadow_q[i], rword);
      end
      is_en:   rdata = 32'(shen_q);
      is_ctrl: rdata = {30'h0, lock_q, 1'b0};
      is_stat: rdata = {29'h0, ovl_q, lock_q, pend_q};
      default: rdata = 32'h0;
    endcase
  end

  assign reg_rdata_o = (reg_req_i && !reg_error_o) ? rdata : 32'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= def_map;
      shen_q   <= DefaultEnable;
      lock_q   <= 1'b0;
    end else if (wr_ok) begin
      if (is_reg) begin
        for (int i = 0; i < int'(NumRegions); i++)
          if (ridx == 5'(i))
            shadow_q[i] <= put_word(shadow_q[i], rword,
                                    reg_wdata_i, AddrMask);
      end
      if (is_en) shen_q <= reg_wdata_i[NumRegions-1:0];
      if (is_ctrl && reg_wdata_i[1]) lock_q <= 1'b1;
    end
  end

`ifdef CARFIELD_ADDR_MAP_OVERLAP_CHECK_EN
  always_comb begin
    overlap = 1'b0;
    for (int i = 0; i < int'(NumRegions); i++) begin
      for (int j = i + 1; j < int'(NumRegions); j++) begin
        if (shen_q[i] && shen_q[j] &&
            (shadow_q[i].size != '0) && (shadow_q[j].size != '0) &&
            ({1'b0, shadow_q[i].base} < region_end(shadow_q[j])) &&
            ({1'b0, shadow_q[j].base} < region_end(shadow_q[i])))
          overlap = 1'b1;
      end
    end
  end
`else
  assign overlap = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      pend_q   <= 1'b0;
      ovl_q    <= 1'b0;
      active_q <= def_map;
      acten_q  <= DefaultEnable;
    end else begin
      unique case (state_q)
        Idle: begin
          if (commit_req) begin
            state_q <= Pending;
            pend_q  <= 1'b1;
          end
        end
        Pending: begin
          if (bus_idle_i) state_q <= Apply;
        end
        Apply: begin
          if (overlap) begin
            ovl_q <= 1'b1;
          end else begin
            ovl_q    <= 1'b0;
            active_q <= shadow_q;
            acten_q  <= shen_q;
          end
          state_q <= Idle;
          pend_q  <= 1'b0;
        end
        default: begin
          state_q <= Idle;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign commit_pending_o = pend_q;

  logic            hit;
  logic [IdxW-1:0] idx;
  logic            dvalid_q;
  logic            dhit_q;
  logic [IdxW-1:0] didx_q;

  carfield_addr_map_decode #(
    .NumRegions(NumRegions),
    .AddrWidth (AddrWidth),
    .IdxW      (IdxW)
  ) u_decode (
    .map_i (active_q),
    .en_i  (acten_q),
    .addr_i(dec_addr_i),
    .hit_o (hit),
    .idx_o (idx)
  );

  assign dec_ready_o = !dvalid_q || dec_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dvalid_q <= 1'b0;
      dhit_q   <= 1'b0;
      didx_q   <= '0;
    end else if (dec_valid_i && dec_ready_o) begin
      dvalid_q <= 1'b1;
      dhit_q   <= hit;
      didx_q   <= idx;
    end else if (dec_ready_i) begin
      dvalid_q <= 1'b0;
    end
  end

  assign dec_valid_o = dvalid_q;
  assign dec_hit_o   = dhit_q;
  assign dec_idx_o   = didx_q;

endmodule
